kernel_altmemddr_0_multiport_arbiter: RTL and testbench

- Parametrised N-port front end for the DDR controller local (Avalon-MM burst) interface; multiplexes NUM_PORTS masters onto one local_* port.
- Round-robin arbitration with write-burst locking.
- Read-return routing is tracked by an in-order tag FIFO, so each port only sees its own read data.
- Sits between system masters and the controller/PHY in the same ctl_clk domain.

---
 rtl/kernel_altmemddr_0_multiport_arbiter.sv | 169 ++++++++++++++++
 tb/tb_kernel_altmemddr_0_multiport_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_altmemddr_0_multiport_arbiter.sv
// N-port round-robin front end for the DDR controller local interface.
// Write bursts lock the grant; an in-order tag FIFO steers read returns to their port.
module kernel_altmemddr_0_multiport_arbiter #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BE_W      = 4,
  parameter int unsigned SIZE_W    = 3,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS*ADDR_W-1:0]    port_address,
  input  logic [NUM_PORTS-1:0]           port_read,
  input  logic [NUM_PORTS-1:0]           port_write,
  input  logic [NUM_PORTS-1:0]           port_burstbegin,
  input  logic [NUM_PORTS*SIZE_W-1:0]    port_size,
  input  logic [NUM_PORTS*DATA_W-1:0]    port_wdata,
  input  logic [NUM_PORTS*BE_W-1:0]      port_be,
  output logic [NUM_PORTS-1:0]           port_ready,
  output logic [DATA_W-1:0]              port_rdata,
  output logic [NUM_PORTS-1:0]           port_rdata_valid,
  output logic [ADDR_W-1:0]              local_address,
  output logic                           local_read_req,
  output logic                           local_write_req,
  output logic                           local_burstbegin,
  output logic [SIZE_W-1:0]              local_size,
  output logic [DATA_W-1:0]              local_wdata,
  output logic [BE_W-1:0]                local_be,
  input  logic                           local_ready,
  input  logic [DATA_W-1:0]              local_rdata,
  input  logic                           local_rdata_valid,
  input  logic                           local_init_done,
  output logic                           tag_overflow_err,
  output logic [$clog2(TAG_DEPTH):0]     outstanding_reads
);

  localparam int unsigned PID_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned TAG_AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(TAG_DEPTH) + 1;

  typedef enum logic [0:0] {S_IDLE, S_WR_BURST} state_e;
  typedef struct packed {
    logic [PID_W-1:0]  pid;
    logic [SIZE_W-1:0] size;
  } tag_t;

  state_e             state_q;
  logic [PID_W-1:0]   rr_q, lock_q;
  logic [SIZE_W-1:0]  beats_q, rcnt_q;
  logic [TAG_AW-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  tag_t               tag_mem [TAG_DEPTH];

  logic [NUM_PORTS-1:0] req;
  logic [PID_W-1:0]     sel;
  logic                 found, grant, is_wr, acc, push, pop, ret_ok, last, full, empty;
  logic [SIZE_W-1:0]    size_sel;
  tag_t                 head;

  function automatic logic [PID_W-1:0] next_port(input logic [PID_W-1:0] p);
    return (p == PID_W'(NUM_PORTS - 1)) ? '0 : p + PID_W'(1);
  endfunction

  function automatic logic [TAG_AW-1:0] next_ptr(input logic [TAG_AW-1:0] p);
    return (p == TAG_AW'(TAG_DEPTH - 1)) ? '0 : p + TAG_AW'(1);
  endfunction

  assign full  = (cnt_q == CNT_W'(TAG_DEPTH));
  assign empty = (cnt_q == '0);
  assign req   = port_write | (port_read & {NUM_PORTS{~full}});

  // Round-robin search from rr_q, or the locked port during a write burst.
  always_comb begin : arb
    int unsigned idx;
    idx   = 0;
    sel   = rr_q;
    found = 1'b0;
    if (state_q == S_WR_BURST) begin
      sel   = lock_q;
      found = port_write[lock_q];
    end else begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (!found && req[PID_W'(idx)]) begin
          found = 1'b1;
          sel   = PID_W'(idx);
        end
      end
    end
  end

  assign grant    = found & local_init_done & ~reset;
  assign is_wr    = port_write[sel];
  assign size_sel = port_size[sel*SIZE_W +: SIZE_W];
  assign acc      = grant & local_ready;
  assign push     = acc & ~is_wr;

  assign local_write_req  = grant & is_wr;
  assign local_read_req   = grant & ~is_wr;
  assign local_burstbegin = grant & port_burstbegin[sel] & (state_q == S_IDLE);
  assign local_address    = grant ? port_address[sel*ADDR_W +: ADDR_W] : '0;
  assign local_size       = grant ? size_sel : '0;
  assign local_wdata      = grant ? port_wdata[sel*DATA_W +: DATA_W] : '0;
  assign local_be         = grant ? port_be[sel*BE_W +: BE_W] : '0;
  assign port_ready       = grant ? (NUM_PORTS'(local_ready) << sel) : '0;

  // Return path: head tag owns incoming beats until its burst length is met.
  assign head             = tag_mem[rptr_q];
  assign ret_ok           = local_rdata_valid & ~empty & ~reset;
  assign last             = ({1'b0, rcnt_q} + (SIZE_W+1)'(1)) >= {1'b0, head.size};
  assign pop              = ret_ok & last;
  assign port_rdata       = local_rdata;
  assign port_rdata_valid = ret_ok ? (NUM_PORTS'(1) << head.pid) : '0;

  assign outstanding_reads = cnt_q;
  assign tag_overflow_err  = err_q;

  always_ff @(posedge clk) begin
    if (push) tag_mem[wptr_q] <= '{pid: sel, size: size_sel};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      lock_q  <= '0;
      beats_q <= '0;
      rcnt_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (acc) begin
            if (is_wr && size_sel > SIZE_W'(1)) begin
              state_q <= S_WR_BURST;
              lock_q  <= sel;
              beats_q <= size_sel - SIZE_W'(1);
            end else begin
              rr_q <= next_port(sel);
            end
          end
        end
        S_WR_BURST: begin
          if (acc) begin
            beats_q <= beats_q - SIZE_W'(1);
            if (beats_q <= SIZE_W'(1)) begin
              state_q <= S_IDLE;
              rr_q    <= next_port(lock_q);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (push) wptr_q <= next_ptr(wptr_q);
      if (pop)  rptr_q <= next_ptr(rptr_q);
      if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
      if (ret_ok) rcnt_q <= pop ? '0 : rcnt_q + SIZE_W'(1);
      if (local_rdata_valid && empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kernel_altmemddr_0_multiport_arbiter.sv
// Scoreboard bench for the multiport arbiter: commands and read returns are
// queued as expected by the stimulus and checked by an independent monitor.
module tb_kernel_altmemddr_0_multiport_arbiter;

  localparam int NP = 2;

  typedef struct packed {
    logic        wr;
    logic [24:0] addr;
    logic [31:0] data;
    logic        bb;
    logic [2:0]  size;
    logic [3:0]  be;
  } cmd_t;

  typedef struct packed {
    logic [1:0]  vld;
    logic [31:0] data;
  } ret_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [2*25-1:0] port_address;
  logic [1:0]     port_read, port_write, port_burstbegin;
  logic [2*3-1:0] port_size;
  logic [2*32-1:0] port_wdata;
  logic [2*4-1:0] port_be;
  logic [1:0]     port_ready, port_rdata_valid;
  logic [31:0]    port_rdata;
  logic [24:0]    local_address;
  logic           local_read_req, local_write_req, local_burstbegin;
  logic [2:0]     local_size;
  logic [31:0]    local_wdata;
  logic [3:0]     local_be;
  logic           local_ready;
  logic [31:0]    local_rdata;
  logic           local_rdata_valid, local_init_done;
  logic           tag_overflow_err;
  logic [3:0]     outstanding_reads;

  int   checks = 0;
  int   failures = 0;
  cmd_t cmd_q[$];
  ret_t ret_q[$];

  kernel_altmemddr_0_multiport_arbiter dut (
    .clk(clk), .reset(reset),
    .port_address(port_address), .port_read(port_read), .port_write(port_write),
    .port_burstbegin(port_burstbegin), .port_size(port_size), .port_wdata(port_wdata),
    .port_be(port_be), .port_ready(port_ready), .port_rdata(port_rdata),
    .port_rdata_valid(port_rdata_valid), .local_address(local_address),
    .local_read_req(local_read_req), .local_write_req(local_write_req),
    .local_burstbegin(local_burstbegin), .local_size(local_size),
    .local_wdata(local_wdata), .local_be(local_be), .local_ready(local_ready),
    .local_rdata(local_rdata), .local_rdata_valid(local_rdata_valid),
    .local_init_done(local_init_done), .tag_overflow_err(tag_overflow_err),
    .outstanding_reads(outstanding_reads)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic rd, input logic wr, input logic bb,
                          input logic [2:0] size, input logic [24:0] addr, input logic [31:0] data);
    port_read[p]            = rd;
    port_write[p]           = wr;
    port_burstbegin[p]      = bb;
    port_size[p*3 +: 3]     = size;
    port_address[p*25 +: 25] = addr;
    port_wdata[p*32 +: 32]  = data;
  endtask

  function automatic cmd_t mk(input logic wr, input logic [24:0] addr, input logic [31:0] data,
                              input logic bb, input logic [2:0] size, input int p);
    cmd_t c;
    c.wr   = wr;
    c.addr = addr;
    c.data = wr ? data : 32'h0;
    c.bb   = bb;
    c.size = size;
    c.be   = (p == 0) ? 4'hF : 4'h3;
    return c;
  endfunction

  task automatic ret_beat(input logic [31:0] d, input logic [1:0] vld);
    local_rdata_valid = 1'b1;
    local_rdata       = d;
    ret_q.push_back('{vld: vld, data: d});
    step();
    local_rdata_valid = 1'b0;
  endtask

  // Monitor: accepted commands and read-return beats, checked against queues.
  always @(negedge clk) begin
    if (!reset) begin
      if ((local_read_req || local_write_req) && local_ready) begin
        cmd_t act, exp;
        act = '{wr: local_write_req, addr: local_address,
                data: local_write_req ? local_wdata : 32'h0,
                bb: local_burstbegin, size: local_size, be: local_be};
        if (cmd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_cmd: got %0h expected none at %0t", act, $time);
        end else begin
          exp = cmd_q.pop_front();
          chk("cmd", 64'(act), 64'(exp));
        end
      end
      if (local_rdata_valid) begin
        ret_t r;
        if (ret_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ret: valid=%b at %0t", port_rdata_valid, $time);
        end else begin
          r = ret_q.pop_front();
          chk("ret_valid", 64'(port_rdata_valid), 64'(r.vld));
          chk("ret_data", 64'(port_rdata), 64'(r.data));
        end
      end else if (port_rdata_valid != 2'b00) begin
        checks++;
        failures++;
        $display("FAIL spurious_valid: got %b expected 00 at %0t", port_rdata_valid, $time);
      end
    end
  end

  initial begin
    reset = 1'b1; local_init_done = 1'b0; local_ready = 1'b1;
    local_rdata = '0; local_rdata_valid = 1'b0;
    port_read = '0; port_write = '0; port_burstbegin = '0;
    port_size = '0; port_address = '0; port_wdata = '0;
    port_be = {4'h3, 4'hF};
    step(); step();
    chk("rst_ready", 64'(port_ready), 64'h0);
    chk("rst_outstanding", 64'(outstanding_reads), 64'h0);
    chk("rst_err", 64'(tag_overflow_err), 64'h0);

    // Not calibrated: requests must not be granted.
    reset = 1'b0;
    set_port(0, 1, 0, 1, 3'd1, 25'h100, 32'h0);
    set_port(1, 1, 0, 1, 3'd1, 25'h200, 32'h0);
    #1;
    chk("noinit_ready", 64'(port_ready), 64'h0);
    chk("noinit_req", 64'({local_read_req, local_write_req}), 64'h0);
    step();

    // Alternating single-beat reads.
    local_init_done = 1'b1;
    for (int i = 0; i < 4; i++)
      cmd_q.push_back(mk(0, (i % 2 == 0) ? 25'h100 : 25'h200, 0, 1, 3'd1, i % 2));
    #1;
    chk("rr_first_ready", 64'(port_ready), 64'h1);
    for (int i = 0; i < 4; i++) step();
    port_read = '0;
    chk("rr_outstanding", 64'(outstanding_reads), 64'd4);
    for (int i = 0; i < 4; i++) ret_beat(32'hA000 + 32'(i), (i % 2 == 0) ? 2'b01 : 2'b10);
    chk("rr_drained", 64'(outstanding_reads), 64'd0);

    // Multi-beat reads: 3 beats to port 0, then 2 to port 1.
    set_port(0, 1, 0, 1, 3'd3, 25'h110, 32'h0);
    set_port(1, 1, 0, 1, 3'd2, 25'h210, 32'h0);
    cmd_q.push_back(mk(0, 25'h110, 0, 1, 3'd3, 0));
    cmd_q.push_back(mk(0, 25'h210, 0, 1, 3'd2, 1));
    step(); port_read[0] = 1'b0;
    step(); port_read[1] = 1'b0;
    chk("mb_outstanding", 64'(outstanding_reads), 64'd2);
    for (int i = 0; i < 5; i++) ret_beat(32'hB000 + 32'(i), (i < 3) ? 2'b01 : 2'b10);
    chk("mb_empty", 64'(outstanding_reads), 64'd0);

    // Move rr pointer to 1 with a lone port-0 read.
    set_port(0, 1, 0, 1, 3'd1, 25'h120, 32'h0);
    cmd_q.push_back(mk(0, 25'h120, 0, 1, 3'd1, 0));
    step(); port_read[0] = 1'b0;
    ret_beat(32'hC000, 2'b01);

    // Port-1 4-beat write locks out a concurrent port-0 read.
    set_port(0, 1, 0, 1, 3'd1, 25'h130, 32'h0);
    for (int b = 0; b < 4; b++) begin
      set_port(1, 0, 1, (b == 0), 3'd4, 25'h230, 32'hD000 + 32'(b));
      cmd_q.push_back(mk(1, 25'h230, 32'hD000 + 32'(b), (b == 0), 3'd4, 1));
      #1;
      chk("burst_ready", 64'(port_ready), 64'h2);
      step();
    end
    port_write[1] = 1'b0;
    cmd_q.push_back(mk(0, 25'h130, 0, 1, 3'd1, 0));
    #1;
    chk("post_burst_ready", 64'(port_ready), 64'h1);
    step(); port_read[0] = 1'b0;
    ret_beat(32'hC100, 2'b01);

    // Fill the tag FIFO with 8 reads; a 9th read stalls while a write passes.
    set_port(0, 1, 0, 1, 3'd1, 25'h140, 32'h0);
    for (int i = 0; i < 8; i++) cmd_q.push_back(mk(0, 25'h140, 0, 1, 3'd1, 0));
    for (int i = 0; i < 8; i++) step();
    chk("full_outstanding", 64'(outstanding_reads), 64'd8);
    chk("full_ready", 64'(port_ready), 64'h0);
    set_port(1, 0, 1, 1, 3'd1, 25'h240, 32'hE000);
    cmd_q.push_back(mk(1, 25'h240, 32'hE000, 1, 3'd1, 1));
    #1;
    chk("full_write_ready", 64'(port_ready), 64'h2);
    step(); port_write[1] = 1'b0;
    #1;
    chk("full_stall_ready", 64'(port_ready), 64'h0);
    ret_beat(32'hF000, 2'b01);
    cmd_q.push_back(mk(0, 25'h140, 0, 1, 3'd1, 0));
    #1;
    chk("refill_ready", 64'(port_ready), 64'h1);
    step(); port_read[0] = 1'b0;
    chk("refill_outstanding", 64'(outstanding_reads), 64'd8);
    for (int i = 0; i < 8; i++) ret_beat(32'hF100 + 32'(i), 2'b01);
    chk("full_drained", 64'(outstanding_reads), 64'd0);

    // Return with no outstanding tag.
    local_rdata_valid = 1'b1; local_rdata = 32'h5555;
    ret_q.push_back('{vld: 2'b00, data: 32'h5555});
    #1;
    chk("ovf_valid", 64'(port_rdata_valid), 64'h0);
    step(); local_rdata_valid = 1'b0;
    chk("ovf_err_set", 64'(tag_overflow_err), 64'h1);
    step(); step(); step();
    chk("ovf_err_sticky", 64'(tag_overflow_err), 64'h1);
    reset = 1'b1;
    step();
    chk("ovf_err_cleared", 64'(tag_overflow_err), 64'h0);
    reset = 1'b0;

    // Reset during beat 2 of a 4-beat write, with a read outstanding.
    set_port(1, 1, 0, 1, 3'd1, 25'h250, 32'h0);
    cmd_q.push_back(mk(0, 25'h250, 0, 1, 3'd1, 1));
    step(); port_read[1] = 1'b0;
    chk("pre_rst_outstanding", 64'(outstanding_reads), 64'd1);
    set_port(0, 0, 1, 1, 3'd4, 25'h150, 32'h7000);
    cmd_q.push_back(mk(1, 25'h150, 32'h7000, 1, 3'd4, 0));
    step();
    set_port(0, 0, 1, 0, 3'd4, 25'h150, 32'h7001);
    reset = 1'b1; local_init_done = 1'b0;
    step();
    chk("midrst_outstanding", 64'(outstanding_reads), 64'd0);
    chk("midrst_ready", 64'(port_ready), 64'h0);
    reset = 1'b0;
    set_port(0, 0, 1, 1, 3'd4, 25'h160, 32'h8000);
    #1;
    chk("midrst_noinit_ready", 64'(port_ready), 64'h0);
    chk("midrst_noinit_req", 64'(local_write_req), 64'h0);
    step();
    local_init_done = 1'b1;
    for (int b = 0; b < 4; b++) begin
      set_port(0, 0, 1, (b == 0), 3'd4, 25'h160, 32'h8000 + 32'(b));
      cmd_q.push_back(mk(1, 25'h160, 32'h8000 + 32'(b), (b == 0), 3'd4, 0));
      #1;
      chk("newburst_ready", 64'(port_ready), 64'h1);
      step();
    end
    port_write = '0;
    step(); step();
    chk("cmd_queue_empty", 64'(cmd_q.size()), 64'd0);
    chk("ret_queue_empty", 64'(ret_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
